// File: rtl/cf_fft_pkg.sv
// Shared definitions for the FFT frame reorder buffer: defaults, FSM state
// encodings and the address bit-reversal helper.
package cf_fft_pkg;

    localparam int LOG2N_DEF = 10;
    localparam int WIDTH_DEF = 16;
    localparam int LOG2N_MAX = 12;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } r_state_t;

    // Reverse the low 'bits' bits of value; bits above 'bits' come back zero.
    function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] value,
                                                    input int bits);
        logic [LOG2N_MAX-1:0] result;
        logic [3:0]           src;
        result = '0;
        for (int i = 0; i < LOG2N_MAX; i++) begin
            if (i < bits) begin
                src       = 4'(bits - 1 - i);
                result[i] = value[src];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cf_fft_reorder_if.sv
// Sample stream bundle around the reorder buffer: the frame source drives the
// inputs, the reorder buffer drives the reordered output stream.
interface cf_fft_reorder_if #(
    parameter int WIDTH = cf_fft_pkg::WIDTH_DEF
);
    logic             sync_i;
    logic             order_i;
    logic [WIDTH-1:0] data_0_i;
    logic [WIDTH-1:0] data_1_i;
    logic             sync_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_0_o;
    logic [WIDTH-1:0] data_1_o;
    logic             resync_o;

    modport master (
        output sync_i, order_i, data_0_i, data_1_i,
        input  sync_o, valid_o, data_0_o, data_1_o, resync_o
    );

    modport slave (
        input  sync_i, order_i, data_0_i, data_1_i,
        output sync_o, valid_o, data_0_o, data_1_o, resync_o
    );
endinterface

// File: rtl/cf_fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module cf_fft_dpram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port and registered read port share the clock.
    // NOTE: memory and read register have no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/cf_fft_reorder.sv
// Ping-pong frame reorder buffer: one bank fills with a frame while the other
// is read out in bit-reversed or natural order.
module cf_fft_reorder
    import cf_fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock_c,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             sync_i,
    input  logic             order_i,
    input  logic [WIDTH-1:0] data_0_i,
    input  logic [WIDTH-1:0] data_1_i,
    output logic             sync_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_0_o,
    output logic [WIDTH-1:0] data_1_o,
    output logic             resync_o
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'((1 << LOG2N) - 1);

    // Per-bank order mode and frame-complete flags.
    logic [1:0] mode;
    logic [1:0] done;

    // Writer.
    w_state_t         w_state, w_state_nxt;
    logic [LOG2N-1:0] wcnt, wcnt_nxt, waddr;
    logic             wbank, wbank_nxt;
    logic             wr_en, wr_first, wr_fin, resync_nxt;

    // Reader.
    r_state_t         r_state, r_state_nxt;
    logic [LOG2N-1:0] rcnt, rcnt_nxt, raddr;
    logic             rbank, rbank_nxt;
    logic             rd_issue, rd_fin;

    // Output pipeline.
    logic             rd_valid, rd_sync;
    logic [2*WIDTH-1:0] rdata;

    // Writer next state: start on sync, fill sequentially, restart on early sync.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = w_state;
        wcnt_nxt    = wcnt;
        wbank_nxt   = wbank;
        waddr       = wcnt;
        wr_en       = 1'b0;
        wr_first    = 1'b0;
        wr_fin      = 1'b0;
        resync_nxt  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (sync_i) begin
                    wr_en       = 1'b1;
                    wr_first    = 1'b1;
                    waddr       = '0;
                    wcnt_nxt    = LOG2N'(1);
                    w_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                wr_en = 1'b1;
                if (sync_i) begin
                    wr_first   = 1'b1;
                    waddr      = '0;
                    wcnt_nxt   = LOG2N'(1);
                    resync_nxt = 1'b1;
                end else if (wcnt == LAST) begin
                    wr_fin      = 1'b1;
                    wbank_nxt   = ~wbank;
                    wcnt_nxt    = '0;
                    w_state_nxt = W_IDLE;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Writer state, bank select, mode latch and resync pulse.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock_c) begin
        if (!reset_i) begin
            w_state  <= W_IDLE;
            wcnt     <= '0;
            wbank    <= 1'b0;
            mode     <= '0;
            resync_o <= 1'b0;
        end else if (enable_i) begin
            w_state  <= w_state_nxt;
            wcnt     <= wcnt_nxt;
            wbank    <= wbank_nxt;
            resync_o <= resync_nxt;
            if (wr_first) mode[wbank] <= order_i;
        end
    end

    // Reader next state: sample 0 is issued from idle as soon as the bank is
    // complete, so back-to-back banks stream without a gap.
    always_comb begin
        r_state_nxt = r_state;
        rcnt_nxt    = rcnt;
        rbank_nxt   = rbank;
        rd_fin      = 1'b0;
        rd_issue    = (r_state == R_READ) || done[rbank];
        case (r_state)
            R_IDLE: begin
                if (done[rbank]) begin
                    r_state_nxt = R_READ;
                    rcnt_nxt    = LOG2N'(1);
                end
            end
            R_READ: begin
                if (rcnt == LAST) begin
                    rd_fin      = 1'b1;
                    rbank_nxt   = ~rbank;
                    rcnt_nxt    = '0;
                    r_state_nxt = R_IDLE;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
        raddr = mode[rbank] ? rcnt : LOG2N'(bitrev(LOG2N_MAX'(rcnt), LOG2N));
    end

    // Reader state and bank select.
    always_ff @(posedge clock_c) begin
        if (!reset_i) begin
            r_state <= R_IDLE;
            rcnt    <= '0;
            rbank   <= 1'b0;
        end else if (enable_i) begin
            r_state <= r_state_nxt;
            rcnt    <= rcnt_nxt;
            rbank   <= rbank_nxt;
        end
    end

    // Bank-complete flags: set by the writer, cleared by the reader.
    always_ff @(posedge clock_c) begin
        if (!reset_i) begin
            done <= '0;
        end else if (enable_i) begin
            if (rd_fin) done[rbank] <= 1'b0;
            if (wr_fin) done[wbank] <= 1'b1;
        end
    end

    cf_fft_dpram #(
        .AW (LOG2N + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clk   (clock_c),
        .we    (enable_i & wr_en),
        .waddr ({wbank, waddr}),
        .wdata ({data_1_i, data_0_i}),
        .re    (enable_i & rd_issue),
        .raddr ({rbank, raddr}),
        .rdata (rdata)
    );

    // Align valid/sync with RAM latency, then register outputs, zeroing idle data.
    always_ff @(posedge clock_c) begin
        if (!reset_i) begin
            rd_valid <= 1'b0;
            rd_sync  <= 1'b0;
            valid_o  <= 1'b0;
            sync_o   <= 1'b0;
            data_0_o <= '0;
            data_1_o <= '0;
        end else if (enable_i) begin
            rd_valid <= rd_issue;
            rd_sync  <= rd_issue && (rcnt == '0);
            valid_o  <= rd_valid;
            sync_o   <= rd_sync;
            data_0_o <= rd_valid ? rdata[WIDTH-1:0]       : '0;
            data_1_o <= rd_valid ? rdata[2*WIDTH-1:WIDTH] : '0;
        end
    end
endmodule

// File: tb/tb_cf_fft_reorder.sv
// Directed bench for the reorder buffer with an 8-sample frame.
module tb_cf_fft_reorder;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset_i;
    logic enable_i;

    cf_fft_reorder_if #(.WIDTH(WIDTH)) bus ();

    cf_fft_reorder #(.LOG2N(LOG2N), .WIDTH(WIDTH)) dut (
        .clock_c  (clk),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .sync_i   (bus.sync_i),
        .order_i  (bus.order_i),
        .data_0_i (bus.data_0_i),
        .data_1_i (bus.data_1_i),
        .sync_o   (bus.sync_o),
        .valid_o  (bus.valid_o),
        .data_0_o (bus.data_0_o),
        .data_1_o (bus.data_1_o),
        .resync_o (bus.resync_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    // Log of enabled edges.
    int          ecnt = 0;
    int          first_sync_edge;
    int          resync_cnt;
    int          zero_viol;
    logic [15:0] out0_q[$];
    logic [15:0] out1_q[$];
    bit          sync_q[$];
    int          idx_q[$];

    task automatic clear_log();
        out0_q.delete(); out1_q.delete(); sync_q.delete(); idx_q.delete();
        first_sync_edge = -1;
        resync_cnt      = 0;
        zero_viol       = 0;
    endtask

    task automatic drive(bit s, bit o, logic [15:0] d);
        bus.sync_i   = s;
        bus.order_i  = o;
        bus.data_0_i = d;
        bus.data_1_i = ~d;
    endtask

    // One clock; outputs sampled 1ns after the edge and logged if enabled.
    task automatic tick();
        bit en      = enable_i;
        bit sync_in = bus.sync_i && reset_i;
        @(posedge clk);
        #1;
        if (en) begin
            if (sync_in && first_sync_edge < 0) first_sync_edge = ecnt;
            if (bus.valid_o) begin
                out0_q.push_back(bus.data_0_o);
                out1_q.push_back(bus.data_1_o);
                sync_q.push_back(bus.sync_o);
                idx_q.push_back(ecnt);
            end else if (bus.data_0_o !== '0 || bus.data_1_o !== '0) begin
                zero_viol++;
            end
            if (bus.resync_o) resync_cnt++;
            ecnt++;
        end
    endtask

    task automatic send_frame(int base, bit order, int len, bit stall);
        for (int i = 0; i < len; i++) begin
            drive(i == 0, order, 16'(base + i));
            if (stall) begin
                enable_i = 1'b0;
                tick();
            end
            enable_i = 1'b1;
            tick();
        end
    endtask

    task automatic idle(int n, bit stall);
        drive(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < n; i++) begin
            enable_i = stall ? ((i % 2) == 1) : 1'b1;
            tick();
        end
        enable_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i  = 1'b0;
        enable_i = 1'b0;
        drive(1'b1, 1'b0, 16'h1234);
        tick();
        tick();
        tests_run++;
        if ({bus.valid_o, bus.sync_o, bus.resync_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 000", {bus.valid_o, bus.sync_o, bus.resync_o});
        end
        tests_run++;
        if (bus.data_0_o !== 16'h0 || bus.data_1_o !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h, expected 0000/0000", bus.data_0_o, bus.data_1_o);
        end
        reset_i  = 1'b1;
        enable_i = 1'b1;
        clear_log();
        idle(12, 1'b0);
        tests_run++;
        if (out0_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_idle_output: got %0d samples, expected 0", out0_q.size());
        end
    endtask

    task automatic test_bitrev();
        clear_log();
        send_frame(0, 1'b0, N, 1'b0);
        idle(12, 1'b0);
        tests_run++;
        if (out0_q.size() != N) begin
            tests_failed++;
            $display("FAIL bitrev_count: got %0d samples, expected %0d", out0_q.size(), N);
        end
        for (int k = 0; k < N && k < out0_q.size(); k++) begin
            tests_run++;
            if (out0_q[k] !== 16'(rev_tab[k]) || out1_q[k] !== ~16'(rev_tab[k])) begin
                tests_failed++;
                $display("FAIL bitrev_data[%0d]: got %h/%h, expected %h/%h", k, out0_q[k], out1_q[k],
                         16'(rev_tab[k]), ~16'(rev_tab[k]));
            end
        end
        if (out0_q.size() == N) begin
            tests_run++;
            if (sync_q[0] !== 1'b1 || sync_q.sum() with (int'(item)) != 1) begin
                tests_failed++;
                $display("FAIL bitrev_sync: got first=%b count=%0d, expected first=1 count=1",
                         sync_q[0], sync_q.sum() with (int'(item)));
            end
            tests_run++;
            if (idx_q[0] - first_sync_edge != N + 1) begin
                tests_failed++;
                $display("FAIL bitrev_latency: got %0d edges, expected %0d", idx_q[0] - first_sync_edge, N + 1);
            end
            tests_run++;
            if (idx_q[N-1] - idx_q[0] != N - 1) begin
                tests_failed++;
                $display("FAIL bitrev_contiguous: got span %0d, expected %0d", idx_q[N-1] - idx_q[0], N - 1);
            end
        end
        tests_run++;
        if (zero_viol != 0) begin
            tests_failed++;
            $display("FAIL idle_data_zero: got %0d nonzero idle samples, expected 0", zero_viol);
        end
    endtask

    task automatic test_natural();
        clear_log();
        send_frame(0, 1'b1, N, 1'b0);
        idle(12, 1'b0);
        tests_run++;
        if (out0_q.size() != N) begin
            tests_failed++;
            $display("FAIL natural_count: got %0d samples, expected %0d", out0_q.size(), N);
        end
        for (int k = 0; k < N && k < out0_q.size(); k++) begin
            tests_run++;
            if (out0_q[k] !== 16'(k) || out1_q[k] !== ~16'(k)) begin
                tests_failed++;
                $display("FAIL natural_data[%0d]: got %h/%h, expected %h/%h", k, out0_q[k], out1_q[k],
                         16'(k), ~16'(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp[$];
        int          bases [3] = '{16'h20, 16'h30, 16'h40};
        bit          orders[3] = '{1'b0, 1'b1, 1'b0};
        clear_log();
        for (int f = 0; f < 3; f++) begin
            send_frame(bases[f], orders[f], N, 1'b0);
            for (int k = 0; k < N; k++) exp.push_back(16'(bases[f] + (orders[f] ? k : rev_tab[k])));
        end
        idle(14, 1'b0);
        tests_run++;
        if (out0_q.size() != 3 * N) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d samples, expected %0d", out0_q.size(), 3 * N);
        end
        for (int k = 0; k < 3 * N && k < out0_q.size(); k++) begin
            tests_run++;
            if (out0_q[k] !== exp[k] || sync_q[k] !== (k % N == 0)) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got %h sync=%b, expected %h sync=%b", k, out0_q[k], sync_q[k],
                         exp[k], (k % N == 0));
            end
        end
        if (out0_q.size() == 3 * N) begin
            tests_run++;
            if (idx_q[3*N-1] - idx_q[0] != 3 * N - 1) begin
                tests_failed++;
                $display("FAIL b2b_gapfree: got span %0d, expected %0d", idx_q[3*N-1] - idx_q[0], 3 * N - 1);
            end
        end
    endtask

    task automatic test_resync();
        clear_log();
        send_frame(16'h50, 1'b0, 5, 1'b0);
        send_frame(10, 1'b0, N, 1'b0);
        idle(12, 1'b0);
        tests_run++;
        if (resync_cnt != 1) begin
            tests_failed++;
            $display("FAIL resync_pulse: got %0d pulses, expected 1", resync_cnt);
        end
        tests_run++;
        if (out0_q.size() != N) begin
            tests_failed++;
            $display("FAIL resync_count: got %0d samples, expected %0d", out0_q.size(), N);
        end
        for (int k = 0; k < N && k < out0_q.size(); k++) begin
            tests_run++;
            if (out0_q[k] !== 16'(10 + rev_tab[k])) begin
                tests_failed++;
                $display("FAIL resync_data[%0d]: got %h, expected %h", k, out0_q[k], 16'(10 + rev_tab[k]));
            end
        end
    endtask

    task automatic test_stall();
        clear_log();
        send_frame(0, 1'b0, N, 1'b1);
        idle(24, 1'b1);
        tests_run++;
        if (out0_q.size() != N) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d samples, expected %0d", out0_q.size(), N);
        end
        for (int k = 0; k < N && k < out0_q.size(); k++) begin
            tests_run++;
            if (out0_q[k] !== 16'(rev_tab[k]) || sync_q[k] !== (k == 0)) begin
                tests_failed++;
                $display("FAIL stall_data[%0d]: got %h sync=%b, expected %h sync=%b", k, out0_q[k], sync_q[k],
                         16'(rev_tab[k]), (k == 0));
            end
        end
        if (out0_q.size() == N) begin
            tests_run++;
            if (idx_q[0] - first_sync_edge != N + 1) begin
                tests_failed++;
                $display("FAIL stall_latency: got %0d enabled edges, expected %0d", idx_q[0] - first_sync_edge, N + 1);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int guard = 0;
        clear_log();
        send_frame(16'h60, 1'b0, N, 1'b0);
        drive(1'b0, 1'b0, 16'h0);
        while (!bus.valid_o && guard < 20) begin
            tick();
            guard++;
        end
        tests_run++;
        if (guard >= 20) begin
            tests_failed++;
            $display("FAIL midread_timeout: got no valid_o within %0d cycles, expected output", guard);
        end
        tick();
        reset_i = 1'b0;
        tick();
        tests_run++;
        if ({bus.valid_o, bus.sync_o, bus.resync_o} !== 3'b000 || bus.data_0_o !== 16'h0 || bus.data_1_o !== 16'h0) begin
            tests_failed++;
            $display("FAIL midread_reset_outputs: got v=%b s=%b r=%b d=%h/%h, expected all zero",
                     bus.valid_o, bus.sync_o, bus.resync_o, bus.data_0_o, bus.data_1_o);
        end
        reset_i = 1'b1;
        idle(20, 1'b0);
        tests_run++;
        if (out0_q.size() != 2) begin
            tests_failed++;
            $display("FAIL midread_no_more_output: got %0d samples, expected 2", out0_q.size());
        end else begin
            tests_run++;
            if (out0_q[0] !== 16'h60 || out0_q[1] !== 16'h64) begin
                tests_failed++;
                $display("FAIL midread_data: got %h,%h, expected 0060,0064", out0_q[0], out0_q[1]);
            end
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_bitrev();
        test_natural();
        test_back_to_back();
        test_resync();
        test_stall();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
